// File: rtl/bf_input_port.sv
// Input port for the core's ',' instruction: a small byte FIFO filled by an external producer,
// drained one byte per acknowledged read request, with a fixed value returned at end-of-input.
//
// state | meaning
// IDLE  | no request in progress
// WAIT  | request seen, FIFO empty and producer not at EOF; waiting for a byte or EOF
// ACK   | delivery made on the entering edge; DInAck high for this one cycle
module bf_input_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] EOF_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_eof,
    input  logic                       DInReq,
    output logic                       DInAck,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             deliver;
    logic             has_data;

    assign has_data = (count != '0);
    assign in_ready = (count != FULL_COUNT);
    assign push     = in_valid & in_ready;
    assign DInAck   = (state == ACK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        deliver    = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (!DInReq) begin
                    // A request dropped while waiting is simply abandoned.
                    state_next = IDLE;
                end else if (has_data) begin
                    deliver    = 1'b1;
                    pop        = 1'b1;
                    state_next = ACK;
                end else if (in_eof) begin
                    deliver    = 1'b1;
                    state_next = ACK;
                end else begin
                    state_next = WAIT;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (deliver) begin
            out <= pop ? mem[rd_ptr] : EOF_VALUE;
        end
    end

endmodule

// File: tb/tb_bf_input_port.sv
// Testbench for bf_input_port: directed scenarios plus random traffic, checked against a
// queue-based model of the port through a scoreboard of expected delivered bytes.
module tb_bf_input_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] EOF_V = 8'h00;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_eof;
    logic             DInReq;
    logic             DInAck;
    logic [WIDTH-1:0] out;
    logic [2:0]       count;

    bf_input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EOF_VALUE(EOF_V)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_eof   (in_eof),
        .DInReq   (DInReq),
        .DInAck   (DInAck),
        .out      (out),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: buffered bytes, byte last handed to the core, whether an ack is showing now.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_out;
    bit               m_ack;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ack = 1'b0;
        m_out = '0;
    endtask

    // One clock edge of the port, from the rules: a request not overlapping an ack is served
    // from the oldest byte, or with EOF_V when nothing is buffered and the producer is done.
    task automatic model_edge();
        int sz;
        bit serve;
        logic [WIDTH-1:0] v;
        sz = mq.size();
        serve = DInReq && !m_ack && (sz > 0 || in_eof);
        if (serve) begin
            if (sz > 0) v = mq.pop_front();
            else        v = EOF_V;
            exp_q.push_back(v);
            m_out = v;
        end
        if (in_valid && sz < DEPTH) mq.push_back(in_data);
        m_ack = serve;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic e);
        @(negedge clock);
        #1;
        in_valid = v;
        in_data  = d;
        DInReq   = r;
        in_eof   = e;
        @(posedge clock);
        model_edge();
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        DInReq   = 1'b0;
        in_eof   = 1'b0;
        #1;
        chk({tag, "_ack"},   int'(DInAck), 0);
        chk({tag, "_out"},   int'(out),    0);
        chk({tag, "_count"}, int'(count),  0);
        model_reset();
        #4;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        logic [WIDTH-1:0] e;
        if (!reset) begin
            chk("ack", int'(DInAck), int'(m_ack));
            if (DInAck) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_on_ack", int'(out), int'(e));
                end
            end
            chk("out_held", int'(out), int'(m_out));
            chk("count", int'(count), mq.size());
            chk("in_ready", int'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
        end
    end

    initial begin
        logic r;
        logic e;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_eof   = 1'b0;
        DInReq   = 1'b0;
        model_reset();
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_ack", int'(DInAck), 0);
        chk("rst_out", int'(out), 0);
        #9;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // 1: two bytes, two requests
        step(1, 8'h2B, 0, 0);
        step(1, 8'h41, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // 2: overfill, then drain across pointer wrap
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, 0);
            step(0, 8'h00, 0, 0);
        end

        // 3: wait on empty, byte arrives
        for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h7F, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        // 4: eof with two bytes buffered
        step(1, 8'h10, 0, 1);
        step(1, 8'h20, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 1);
            step(0, 8'h00, 0, 1);
        end
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 0, 0);

        // 5: push and pop on the same edge
        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 0, 0);
        step(1, 8'hA3, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // 6: reset in WAIT, then in ACK, then refill
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        async_reset("rst_wait");
        step(1, 8'hB1, 0, 0);
        step(0, 8'h00, 1, 0);
        #2;
        chk("ack_before_rst", int'(DInAck), 1);
        async_reset("rst_ack");
        step(1, 8'hC5, 0, 0);
        step(1, 8'hC6, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Random traffic
        r = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!r)          r = ($urandom_range(0, 2) == 0);
            else if (m_ack)  r = 1'b0;
            else if ($urandom_range(0, 19) == 0) r = 1'b0;
            if ($urandom_range(0, 29) == 0) e = ~e;
            step(logic'($urandom_range(0, 1)), 8'($urandom), r, e);
        end
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_input_port.md
Name: bf_input_port

Overview:
- Input-side counterpart to the machine's data-output register.
- Buffers bytes from an external producer in a small FIFO.
- Delivers one byte per core read request; the `,` instruction raises the request and the core stalls until the acknowledge.
- Signals end-of-input to the core by returning a fixed value.

Parameters:
- WIDTH, 8, data byte width.
- DEPTH, 4, FIFO entries. Must be a power of two, 2 or more.
- EOF_VALUE, 0, byte returned when the FIFO is empty and in_eof is high.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  producer byte.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  FIFO can accept a byte; equals !full. Combinational from state.
- in_eof  input  1  level: the producer has no further bytes.
- DInReq  input  1  core read request; held high until DInAck is seen.
- DInAck  output  1  one-cycle pulse; out is valid in this cycle and after it.
- out  output  WIDTH  last delivered byte; held until the next delivery.
- count  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, immediate):
  - FIFO emptied; read and write pointers = 0; count = 0.
  - out = 0; DInAck = 0; state = IDLE.
  - in_ready = 1 after reset releases.
- Push: on a rising edge with in_valid & in_ready, in_data is written at the write pointer. Pointer wraps modulo DEPTH.
- Push while full: in_valid with in_ready = 0 is ignored. The byte is not stored and nothing else changes.
- Pop: occurs only on a delivery edge. Read pointer wraps modulo DEPTH.
- Same-edge push and pop: both take effect and count is unchanged.
- Full FIFO: a pop never frees a slot for a push on the same edge, because in_ready was 0 at that edge.
- FSM states and transitions:
  - IDLE, DInReq=0: stay in IDLE.
  - IDLE, DInReq=1, count>0: on this edge out <= head byte, pop, DInAck <= 1, go to ACK.
  - IDLE, DInReq=1, count=0, in_eof=0: go to WAIT.
  - IDLE, DInReq=1, count=0, in_eof=1: out <= EOF_VALUE, DInAck <= 1, go to ACK. No pop.
  - WAIT, count>0: deliver as from IDLE and go to ACK.
  - WAIT, count=0, in_eof=1: deliver EOF_VALUE and go to ACK.
  - WAIT, otherwise: stay in WAIT.
  - WAIT, DInReq dropping: the request is abandoned and the state returns to IDLE with no delivery.
  - ACK: DInAck = 1 for exactly this cycle. DInReq is ignored. Next state is IDLE and DInAck <= 0.
- Latency:
  - Request sampled at edge N with data present: DInAck high in cycle N+1.
  - Minimum spacing between two acks is 2 cycles.
- Arrival while waiting: a byte pushed at edge N while in WAIT makes count>0 after N. Delivery happens at edge N+1 and DInAck is high in cycle N+2. There is no bypass from in_data to out.
- in_eof priority: buffered bytes are always drained before EOF_VALUE is returned.
- Repeated EOF: EOF_VALUE is returned for every request while the FIFO is empty and in_eof is high.
- Reset mid-operation: a pending WAIT or ACK is discarded, buffered bytes are lost, and DInAck drops immediately.
- count: range is 0 to DEPTH inclusive. It never over- or under-flows.
- out: changes only on a delivery edge or on reset.

Test Plan:
1. Reset, then push 0x2B, 0x41. Pulse DInReq until ack → DInAck in cycle N+1, out=0x2B, count 2→1. Second request → out=0x41, count=0.
2. Push 5 bytes 0x01..0x05 back-to-back with DEPTH=4 → in_ready drops after 4 pushes and 0x05 is discarded, count=4. Requests return 0x01..0x04 in order, exercising pointer wrap.
3. DInReq with the FIFO empty and in_eof=0 → DInAck stays low in WAIT for 10 cycles. Push 0x7F → DInAck two cycles after the push edge, out=0x7F.
4. in_eof=1 with 2 bytes buffered (0x10, 0x20) → three requests return 0x10, 0x20, EOF_VALUE (0x00), the last without a pop. count ends at 0.
5. Push and request on the same edge with count=2 → count remains 2, out = oldest byte.
6. Assert reset asynchronously in WAIT and again in ACK → DInAck, out, and count are 0 at once with no clock edge. The next request after refilling returns the new first byte.
